// File: rtl/apb_regfile_if.sv
// APB slave bus bundle for apb_regfile; carries pstrb only when APB_REGFILE_PSTRB_EN is defined.
interface apb_regfile_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
`ifdef APB_REGFILE_PSTRB_EN
  logic [DATA_W/8-1:0] pstrb;

  modport master (output paddr, psel, penable, pwrite, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata, pstrb,
                  output prdata, pready, pslverr);
`else
  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output prdata, pready, pslverr);
`endif
endinterface

// File: rtl/apb_regfile.sv
// APB slave register bank with wait states, error response, read-only status registers and write pulses.
// Optional APB4 byte strobes: define APB_REGFILE_PSTRB_EN.
module apb_regfile #(
  parameter int                  DATA_W      = 32,
  parameter int                  ADDR_W      = 8,
  parameter int                  NUM_REGS    = 8,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  apb_regfile_if.slave               bus,
  input  logic [NUM_REGS*DATA_W-1:0] ro_in,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]        wr_pulse
);
  localparam int         AL    = $clog2(DATA_W / 8);
  localparam int         IDX_W = ADDR_W - AL;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state, next_state, phase;
  logic [3:0]        cnt, next_cnt;
  logic              ready, next_ready;
  logic              slverr, next_slverr;
  logic [DATA_W-1:0] rdata, next_rdata;
  logic              commit;
  logic [IDX_W-1:0]  idx;
  logic              in_range, is_ro, err;
  logic [DATA_W-1:0] rd_value, wr_value;
  logic [DATA_W-1:0] regs [NUM_REGS];

`ifdef APB_REGFILE_PSTRB_EN
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [DATA_W/8-1:0] strb);
    logic [DATA_W-1:0] res;
    for (int b = 0; b < DATA_W / 8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction
`endif

  assign idx = bus.paddr[ADDR_W-1:AL];

  // Address decode: range check, read-only lookup and the addressed register's current value
  always_comb begin
    in_range = 1'b0;
    is_ro    = 1'b0;
    rd_value = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      in_range = in_range | (32'(idx) == k[31:0]);
      is_ro    = is_ro | ((32'(idx) == k[31:0]) & RO_MASK[k]);
      rd_value = rd_value | ((32'(idx) == k[31:0])
                             ? (RO_MASK[k] ? ro_in[k*DATA_W +: DATA_W] : regs[k])
                             : '0);
    end
  end

  assign err = ~in_range | (bus.pwrite & is_ro);

  // For RW targets rd_value is the old register content, which byte merging needs
`ifdef APB_REGFILE_PSTRB_EN
  assign wr_value = merge_bytes(rd_value, bus.pwdata, bus.pstrb);
`else
  assign wr_value = bus.pwdata;
`endif

  // A select seen while idle makes the current cycle the setup phase, with or without penable
  assign phase = (state == IDLE && bus.psel) ? SETUP : state;

  // Next-state logic; completion outputs are registered one edge ahead so pready lands in the last access cycle
  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    next_ready  = 1'b0;
    next_slverr = 1'b0;
    next_rdata  = '0;
    commit      = 1'b0;
    case (phase)
      IDLE: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
      SETUP: begin
        next_state = ACCESS;
        next_cnt   = WS;
        if (WS == 4'd0) begin
          next_ready  = 1'b1;
          next_slverr = err;
          next_rdata  = bus.pwrite ? '0 : rd_value;
        end else begin
          next_ready  = 1'b0;
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          next_state = IDLE;
          next_cnt   = 4'd0;
        end else if (cnt != 4'd0) begin
          next_cnt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            next_ready  = 1'b1;
            next_slverr = err;
            next_rdata  = bus.pwrite ? '0 : rd_value;
          end else begin
            next_ready  = 1'b0;
          end
        end else begin
          commit     = bus.pwrite & ~err;
          next_state = IDLE;
          next_cnt   = 4'd0;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // FSM state, wait counter and registered bus responses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      ready  <= 1'b0;
      slverr <= 1'b0;
      rdata  <= '0;
    end else begin
      state  <= next_state;
      cnt    <= next_cnt;
      ready  <= next_ready;
      slverr <= next_slverr;
      rdata  <= next_rdata;
    end
  end

  // Register storage and per-register write pulse, both updated on the completing edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
      wr_pulse <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (commit && (32'(idx) == k[31:0]) && !RO_MASK[k]) begin
          regs[k]     <= wr_value;
          wr_pulse[k] <= 1'b1;
        end else begin
          wr_pulse[k] <= 1'b0;
        end
      end
    end
  end

  assign bus.pready  = ready;
  assign bus.pslverr = slverr;
  assign bus.prdata  = rdata;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = RO_MASK[g] ? ro_in[g*DATA_W +: DATA_W] : regs[g];
  end
endmodule

// File: tb/tb_apb_regfile.sv
// Self-checking bench for apb_regfile: two instances (0 and 3 wait states) behind one APB master.
module tb_apb_regfile;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0]    t_addr;
  logic             t_psel, t_pen, t_wr;
  logic [DW-1:0]    t_wdata;
  logic [DW/8-1:0]  t_strb;
  int               which;
  logic [NR*DW-1:0] ro_in;
  logic [NR*DW-1:0] reg_out0, reg_out3;
  logic [NR-1:0]    wp0, wp3;
  logic [7:0]       ro_mask;

  apb_regfile_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  apb_regfile_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  assign b0.paddr   = t_addr;
  assign b0.psel    = t_psel && (which == 0);
  assign b0.penable = t_pen;
  assign b0.pwrite  = t_wr;
  assign b0.pwdata  = t_wdata;
  assign b3.paddr   = t_addr;
  assign b3.psel    = t_psel && (which == 3);
  assign b3.penable = t_pen;
  assign b3.pwrite  = t_wr;
  assign b3.pwdata  = t_wdata;
`ifdef APB_REGFILE_PSTRB_EN
  assign b0.pstrb = t_strb;
  assign b3.pstrb = t_strb;
`endif

  apb_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_STATES(0), .RO_MASK(8'h80)) dut0 (
    .clk(clk), .reset(reset), .bus(b0), .ro_in(ro_in), .reg_out(reg_out0), .wr_pulse(wp0));
  apb_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_STATES(3), .RO_MASK(8'h80)) dut3 (
    .clk(clk), .reset(reset), .bus(b3), .ro_in(ro_in), .reg_out(reg_out3), .wr_pulse(wp3));

  logic          cur_rdy, cur_err;
  logic [DW-1:0] cur_rdata;
  logic [NR-1:0] cur_wp;
  assign cur_rdy   = (which == 3) ? b3.pready  : b0.pready;
  assign cur_err   = (which == 3) ? b3.pslverr : b0.pslverr;
  assign cur_rdata = (which == 3) ? b3.prdata  : b0.prdata;
  assign cur_wp    = (which == 3) ? wp3 : wp0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference register contents per instance
  logic [DW-1:0] m0 [NR];
  logic [DW-1:0] m3 [NR];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mflat(input int w);
    logic [255:0] r;
    for (int i = 0; i < NR; i++) begin
      r[i*32 +: 32] = ro_mask[i] ? ro_in[i*32 +: 32] : ((w == 3) ? m3[i] : m0[i]);
    end
    return r;
  endfunction

  // Spec rules: decode, error, read value, write effect, expected pulse
  task automatic model_xfer(input int w, input logic wr, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] erd, output logic eer, output logic [7:0] ep);
    int  i;
    logic inr;
    i   = int'(a[7:2]);
    inr = (i < NR);
    eer = !inr || (wr && ro_mask[i % NR]);
    erd = 32'h0;
    ep  = 8'h00;
    if (!wr && inr) erd = ro_mask[i] ? ro_in[i*32 +: 32] : ((w == 3) ? m3[i] : m0[i]);
    if (wr && !eer) begin
      ep = 8'h01 << i;
      if (w == 3) m3[i] = d;
      else        m0[i] = d;
    end
  endtask

  task automatic xfer(input int w, input logic wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int cyc,
                      output logic [7:0] p1, output logic [7:0] p2, output logic idle_bad);
    logic got;
    which = w;
    rd = 32'h0; er = 1'b0; got = 1'b0;
    @(posedge clk); #1;
    t_addr = a; t_wr = wr; t_wdata = d; t_psel = 1'b1; t_pen = 1'b0;
    cyc = 1;
    idle_bad = (cur_rdy !== 1'b0) || (cur_rdata !== 32'h0);
    @(posedge clk); #1;
    t_pen = 1'b1;
    cyc = 2;
    for (int i = 0; i < 40 && !got; i++) begin
      if (cur_rdy === 1'b1) begin
        got = 1'b1; rd = cur_rdata; er = cur_err;
      end else begin
        if (cur_rdata !== 32'h0) idle_bad = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!got) cyc = -1;
    @(posedge clk); #1;
    t_psel = 1'b0; t_pen = 1'b0;
    p1 = cur_wp;
    if (cur_rdy !== 1'b0 || cur_rdata !== 32'h0) idle_bad = 1'b1;
    @(posedge clk); #1;
    p2 = cur_wp;
  endtask

  typedef struct {
    int          w;
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
    int          cyc;
    logic [7:0]  p;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] rd, erd;
  logic        er, eer, ib, rw;
  logic [7:0]  p1, p2, ep, ra;
  logic [31:0] rdat;
  int          cyc, w, bad;

  initial begin
    ro_mask = 8'h80;
    t_addr = '0; t_psel = 1'b0; t_pen = 1'b0; t_wr = 1'b0; t_wdata = '0; t_strb = '1;
    which = 0;
    for (int i = 0; i < NR; i++) ro_in[i*32 +: 32] = $urandom;
    ro_in[255:224] = 32'h12345678;
    for (int i = 0; i < NR; i++) begin m0[i] = 32'h0; m3[i] = 32'h0; end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", 256'({b0.pready, b3.pready}), 256'(2'b00));
    check("rst_prdata", 256'({b0.prdata, b3.prdata}), 256'(64'h0));
    check("rst_pslverr", 256'({b0.pslverr, b3.pslverr}), 256'(2'b00));
    check("rst_wr_pulse", 256'({wp0, wp3}), 256'(16'h0));
    check("rst_reg_out", 256'({reg_out0[223:0], reg_out3[223:0]}), 256'(0));
    reset = 1'b1;

    tbl[0]  = '{0, 1'b1, 8'h04, 32'hDEADBEEF, 32'h0,        1'b0, 2, 8'h02};
    tbl[1]  = '{0, 1'b0, 8'h04, 32'h0,        32'hDEADBEEF, 1'b0, 2, 8'h00};
    tbl[2]  = '{3, 1'b0, 8'h00, 32'h0,        32'h0,        1'b0, 5, 8'h00};
    tbl[3]  = '{0, 1'b0, 8'h1C, 32'h0,        32'h12345678, 1'b0, 2, 8'h00};
    tbl[4]  = '{0, 1'b1, 8'h1C, 32'hFFFFFFFF, 32'h0,        1'b1, 2, 8'h00};
    tbl[5]  = '{0, 1'b0, 8'h1C, 32'h0,        32'h12345678, 1'b0, 2, 8'h00};
    tbl[6]  = '{0, 1'b1, 8'h20, 32'hCAFEF00D, 32'h0,        1'b1, 2, 8'h00};
    tbl[7]  = '{0, 1'b0, 8'h20, 32'h0,        32'h0,        1'b1, 2, 8'h00};
    tbl[8]  = '{3, 1'b1, 8'h0B, 32'hA5A5A5A5, 32'h0,        1'b0, 5, 8'h04};
    tbl[9]  = '{3, 1'b0, 8'h08, 32'h0,        32'hA5A5A5A5, 1'b0, 5, 8'h00};
    tbl[10] = '{3, 1'b1, 8'h1F, 32'h0BADF00D, 32'h0,        1'b1, 5, 8'h00};
    tbl[11] = '{0, 1'b0, 8'hFC, 32'h0,        32'h0,        1'b1, 2, 8'h00};

    foreach (tbl[i]) begin
      xfer(tbl[i].w, tbl[i].wr, tbl[i].a, tbl[i].d, rd, er, cyc, p1, p2, ib);
      model_xfer(tbl[i].w, tbl[i].wr, tbl[i].a, tbl[i].d, erd, eer, ep);
      check($sformatf("tbl%0d_prdata", i), 256'(rd), 256'(tbl[i].rd));
      check($sformatf("tbl%0d_pslverr", i), 256'(er), 256'(tbl[i].er));
      check($sformatf("tbl%0d_latency", i), 256'(cyc), 256'(tbl[i].cyc));
      check($sformatf("tbl%0d_wr_pulse", i), 256'(p1), 256'(tbl[i].p));
      check($sformatf("tbl%0d_pulse_end", i), 256'(p2), 256'(8'h00));
      check($sformatf("tbl%0d_idle_out", i), 256'(ib), 256'(1'b0));
      check($sformatf("tbl%0d_reg_out", i), (tbl[i].w == 3) ? reg_out3 : reg_out0, mflat(tbl[i].w));
    end

    // Abort: psel dropped during wait states of a write of 0x55 to reg2
    which = 3; bad = 0;
    @(posedge clk); #1;
    t_addr = 8'h08; t_wr = 1'b1; t_wdata = 32'h55; t_psel = 1'b1; t_pen = 1'b0;
    @(posedge clk); #1; t_pen = 1'b1;
    @(posedge clk); #1;
    if (b3.pready !== 1'b0) bad++;
    t_psel = 1'b0; t_pen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (b3.pready !== 1'b0 || wp3 !== 8'h00) bad++;
    end
    check("abort_no_ready_pulse", 256'(bad), 256'(0));
    check("abort_reg2", 256'(reg_out3[95:64]), 256'(32'hA5A5A5A5));

    // Setup skipped: psel and penable together from idle still complete in the next cycle
    which = 0;
    @(posedge clk); #1;
    t_addr = 8'h04; t_wr = 1'b0; t_psel = 1'b1; t_pen = 1'b1;
    @(posedge clk); #1;
    check("noset_pready", 256'(b0.pready), 256'(1'b1));
    check("noset_prdata", 256'(b0.prdata), 256'(32'hDEADBEEF));
    t_psel = 1'b0; t_pen = 1'b0;
    @(posedge clk); #1;

`ifdef APB_REGFILE_PSTRB_EN
    xfer(0, 1'b1, 8'h0C, 32'h11223344, rd, er, cyc, p1, p2, ib);
    t_strb = 4'b0101;
    xfer(0, 1'b1, 8'h0C, 32'hAABBCCDD, rd, er, cyc, p1, p2, ib);
    check("strb_reg3", 256'(reg_out0[127:96]), 256'(32'h11BB33DD));
    check("strb_pulse", 256'(p1), 256'(8'h08));
    m0[3] = 32'h11BB33DD;
    t_strb = '1;
`endif

    // Randomized traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      if (n % 25 == 0) begin
        for (int i = 0; i < NR; i++) ro_in[i*32 +: 32] = $urandom;
      end
      w  = ($urandom_range(0, 1) == 0) ? 0 : 3;
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
      rdat = $urandom;
      xfer(w, rw, ra, rdat, rd, er, cyc, p1, p2, ib);
      model_xfer(w, rw, ra, rdat, erd, eer, ep);
      check($sformatf("rnd%0d_prdata", n), 256'(rd), 256'(erd));
      check($sformatf("rnd%0d_pslverr", n), 256'(er), 256'(eer));
      check($sformatf("rnd%0d_latency", n), 256'(cyc), 256'((w == 3) ? 5 : 2));
      check($sformatf("rnd%0d_wr_pulse", n), 256'({p1, p2}), 256'({ep, 8'h00}));
      check($sformatf("rnd%0d_idle_out", n), 256'(ib), 256'(1'b0));
      check($sformatf("rnd%0d_reg_out", n), (w == 3) ? reg_out3 : reg_out0, mflat(w));
    end

    // Reset in the middle of an access phase
    which = 3;
    @(posedge clk); #1;
    t_addr = 8'h0C; t_wr = 1'b1; t_wdata = 32'h77777777; t_psel = 1'b1; t_pen = 1'b0;
    @(posedge clk); #1; t_pen = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_pready", 256'({b0.pready, b3.pready}), 256'(2'b00));
    check("midrst_prdata", 256'({b0.prdata, b3.prdata}), 256'(64'h0));
    check("midrst_pslverr", 256'({b0.pslverr, b3.pslverr}), 256'(2'b00));
    check("midrst_reg_out", 256'({reg_out0[223:0], reg_out3[223:0]}), 256'(0));
    t_psel = 1'b0; t_pen = 1'b0;
    @(posedge clk); #1;
    check("midrst_wr_pulse", 256'({wp0, wp3}), 256'(16'h0));
    reset = 1'b1;
    for (int i = 0; i < NR; i++) begin m0[i] = 32'h0; m3[i] = 32'h0; end
    xfer(3, 1'b0, 8'h0C, 32'h0, rd, er, cyc, p1, p2, ib);
    check("postrst_read", 256'({rd, er}), 256'({32'h0, 1'b0}));
    check("postrst_latency", 256'(cyc), 256'(5));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_regfile.md
Name: apb_regfile

Overview:
Parametrised APB slave register bank, the next generation of the team's APB peripheral register block. It holds NUM_REGS control/status registers of DATA_W bits behind a standard APB setup/access handshake. It adds programmable wait states, PREADY/PSLVERR signalling, read-only status registers and per-register write pulses. It sits between the system APB bridge and peripheral control logic.

Parameters:
DATA_W, 32, register and bus data width; legal values 8, 16, 32.
ADDR_W, 8, PADDR width (byte address).
NUM_REGS, 8, number of registers; must satisfy NUM_REGS <= 2^(ADDR_W-AL), where AL = log2(DATA_W/8).
WAIT_STATES, 0, extra ACCESS cycles before PREADY; range 0..15.
RO_MASK, 0, NUM_REGS-bit mask; bit i = 1 makes register i read-only, sourced from ro_in.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
paddr  in  ADDR_W  APB byte address
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  1 = write, 0 = read
pwdata  in  DATA_W  write data
prdata  out  DATA_W  read data, registered
pready  out  1  transfer complete
pslverr  out  1  transfer error, valid only while pready = 1
ro_in  in  NUM_REGS*DATA_W  status values for read-only registers; register i uses slice [i*DATA_W +: DATA_W]
reg_out  out  NUM_REGS*DATA_W  current register contents, flattened the same way
wr_pulse  out  NUM_REGS  one-cycle pulse per successfully written register

Behaviour:
- Reset is asynchronous and active-low. While it is low: all RW registers are 0; prdata, pready, pslverr and wr_pulse are 0; the FSM is in IDLE; the wait counter is 0.
- Decode: idx = paddr[ADDR_W-1:AL]. Bits paddr[AL-1:0] are ignored.
- Error condition: err = (idx >= NUM_REGS) OR (pwrite AND RO_MASK[idx]).
- FSM states are IDLE, SETUP and ACCESS.
- IDLE: moves to SETUP when psel = 1 and penable = 0. If psel = 1 and penable = 1 arrive without a setup phase (protocol violation), the FSM also enters SETUP and treats that cycle as setup.
- SETUP: moves to ACCESS on the next clk. The wait counter is loaded with WAIT_STATES.
- ACCESS: while the counter is nonzero, it decrements and pready stays 0.
- When the counter is 0, the block drives pready = 1 for exactly one cycle and pslverr = err. On the same clk edge it commits the write, or registers prdata.
- After completion: go to SETUP if psel = 1 and penable = 0 (back-to-back transfer), otherwise IDLE.
- Latency: with WAIT_STATES = 0, pready is asserted in the first access cycle. This is a zero-wait APB transfer, 2 cycles total. Each wait state adds one cycle.
- Write commit happens only on the completing cycle, only if err = 0, and only for RW registers.
  - Writes take effect on that clk edge.
  - reg_out updates and wr_pulse[idx] = 1 on the following cycle, for exactly one cycle.
- Read: prdata = register content, or ro_in slice if RO_MASK[idx] = 1, or 0 if idx is out of range.
  - prdata is registered.
  - It is valid while pready = 1 and is driven to 0 in all other cycles.
- If psel drops in ACCESS before completion, the transfer is aborted: return to IDLE, no write, no pready.
- Address and data are sampled on the completing cycle. The master must hold them stable per APB; the block does not check this.
- Read-only register writes return pslverr = 1 and leave the register unchanged.
- Reset asserted mid-transfer aborts it immediately. No partial write occurs.

Optional Feature:
Macro APB_REGFILE_PSTRB_EN.
- Defined: an extra input pstrb [DATA_W/8] is present (APB4 byte strobes). On write commit, only bytes with pstrb[b] = 1 update. pstrb = 0 on a write is still a successful transfer with no data change, and wr_pulse still fires.
- Undefined: no pstrb port; all bytes are written.

Test Plan:
- Reset, WAIT_STATES = 0: write 0xDEADBEEF to paddr 0x04 -> pready high in the 2nd cycle, pslverr = 0, reg_out[63:32] = 0xDEADBEEF, wr_pulse = 8'b0000_0010 for one cycle. Read back 0x04 -> prdata = 0xDEADBEEF.
- WAIT_STATES = 3: read paddr 0x00 -> pready low for 3 access cycles, high on the 4th; 5 cycles total from setup.
- RO_MASK = 8'h80, ro_in reg7 = 0x12345678: read paddr 0x1C -> 0x12345678. Write 0xFFFFFFFF -> pslverr = 1, no wr_pulse, read still 0x12345678.
- Out of range, NUM_REGS = 8: write/read paddr 0x20 -> pslverr = 1, prdata = 0, no register changes.
- Abort: drop psel during wait states on a write of 0x55 to reg2 -> no pready, reg2 unchanged. Separately, assert reset mid-access -> all outputs 0.
- APB_REGFILE_PSTRB_EN defined: reg3 = 0x11223344, write 0xAABBCCDD with pstrb = 4'b0101 -> reg3 = 0x11BB33DD.
